// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states
// and the mux/ALU select codes the datapath and ALU control agree on.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_EX_U     = 4'd4,
    S_EX_AUIPC = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [2:0] ALU_OP_R      = 3'b000;
  localparam logic [2:0] ALU_OP_ILOGIC = 3'b001;
  localparam logic [2:0] ALU_OP_ADD    = 3'b010;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b011;
  localparam logic [2:0] ALU_OP_LUI    = 3'b100;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  // Jump opcodes fall through to TRAP when jumps are configured out.
  function automatic state_e decode_dispatch(input logic [6:0] op, input logic jumps_en);
    state_e nxt;
    nxt = S_TRAP;
    case (op)
      OP_R_TYPE: nxt = S_EX_R;
      OP_I_ALU:  nxt = S_EX_I;
      OP_LUI:    nxt = S_EX_U;
      OP_AUIPC:  nxt = S_EX_AUIPC;
      OP_LOAD:   nxt = S_MEM_ADDR;
      OP_STORE:  nxt = S_MEM_ADDR;
      OP_BRANCH: nxt = S_BRANCH;
      OP_JAL:    nxt = jumps_en ? S_JAL : S_TRAP;
      OP_JALR:   nxt = jumps_en ? S_JALR : S_TRAP;
      default:   nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Control-word ROM: maps the registered FSM state to the raw datapath controls.
// Ready qualification and reset gating of the strobes are applied by the caller.
module ctrl_output_decode
  import rv_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = PC_SRC_ALU;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = M2R_ALUOUT;
    reg_write_o     = 1'b0;
    alu_src_a_o     = SRC_A_PC;
    alu_src_b_o     = SRC_B_RS2;
    alu_op_o        = ALU_OP_R;
    case (state_e'(state_i))
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_OP_ADD;
        ir_write_o  = 1'b1;
        pc_write_o  = 1'b1;
      end
      // Precompute the branch/jump target into ALUOut while the opcode is examined.
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      S_EX_R: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_OP_R;
      end
      S_EX_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ILOGIC;
      end
      S_EX_U: begin
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_LUI;
      end
      S_EX_AUIPC: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_WB_ALU: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_ALUOUT;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_BRANCH: begin
        alu_src_a_o     = SRC_A_RS1;
        alu_src_b_o     = SRC_B_RS2;
        alu_op_o        = ALU_OP_BRANCH;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PC_SRC_ALUOUT;
      end
      S_JAL: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_PC;
        pc_write_o   = 1'b1;
        pc_src_o     = PC_SRC_ALUOUT;
      end
      S_JALR: begin
        alu_src_a_o  = SRC_A_RS1;
        alu_src_b_o  = SRC_B_IMM;
        alu_op_o     = ALU_OP_ADD;
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_PC;
        pc_write_o   = 1'b1;
        pc_src_o     = PC_SRC_JALR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control unit: sequences each instruction through the shared
// memory and ALU, traps unknown opcodes and counts retired instructions.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int ENABLE_JUMPS  = 1,
  parameter int RETIRE_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          Op_i,
  input  logic                Mem_Ready_i,
  output logic                PC_Write_o,
  output logic                PC_Write_Cond_o,
  output logic [1:0]          PC_Src_o,
  output logic                IorD_o,
  output logic                Mem_Read_o,
  output logic                Mem_Write_o,
  output logic                IR_Write_o,
  output logic [1:0]          Mem_to_Reg_o,
  output logic                Reg_Write_o,
  output logic [1:0]          ALU_Src_A_o,
  output logic [1:0]          ALU_Src_B_o,
  output logic [2:0]          ALU_Op_o,
  output logic                Illegal_o,
  output logic [3:0]          State_o,
  output logic [RETIRE_W-1:0] Retired_o
);

  state_e                state_q;
  logic [6:0]            op_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic [RETIRE_W-1:0]   retired_d;
  logic                  illegal_q;
  logic                  rdy;
  logic                  fetch_hold;
  state_e                dispatch;

  logic       dec_pc_write;
  logic       dec_pc_write_cond;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_ir_write;
  logic       dec_reg_write;

  assign rdy        = (USE_MEM_READY != 0) ? Mem_Ready_i : 1'b1;
  assign retired_d  = retired_q + RETIRE_W'(1);
  assign dispatch   = decode_dispatch(Op_i, ENABLE_JUMPS != 0);
  assign fetch_hold = (state_q == S_FETCH) && !rdy;

  // Waiting states hold until rdy; every return to FETCH retires one instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (rdy) state_q <= S_DECODE;
        end
        S_DECODE: begin
          op_q    <= Op_i;
          state_q <= dispatch;
          if (dispatch == S_TRAP) illegal_q <= 1'b1;
        end
        S_EX_R, S_EX_I, S_EX_U, S_EX_AUIPC: state_q <= S_WB_ALU;
        S_MEM_ADDR: state_q <= (op_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (rdy) state_q <= S_WB_MEM;
        end
        S_MEM_WR: begin
          if (rdy) begin
            state_q   <= S_FETCH;
            retired_q <= retired_d;
          end
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: begin
          state_q   <= S_FETCH;
          retired_q <= retired_d;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  ctrl_output_decode u_decode (
    .state_i         (state_q),
    .pc_write_o      (dec_pc_write),
    .pc_write_cond_o (dec_pc_write_cond),
    .pc_src_o        (PC_Src_o),
    .iord_o          (IorD_o),
    .mem_read_o      (dec_mem_read),
    .mem_write_o     (dec_mem_write),
    .ir_write_o      (dec_ir_write),
    .mem_to_reg_o    (Mem_to_Reg_o),
    .reg_write_o     (dec_reg_write),
    .alu_src_a_o     (ALU_Src_A_o),
    .alu_src_b_o     (ALU_Src_B_o),
    .alu_op_o        (ALU_Op_o)
  );

  // A stalled fetch must not latch the IR or advance the PC; reset silences every strobe.
  assign PC_Write_o      = dec_pc_write && !fetch_hold && !reset;
  assign IR_Write_o      = dec_ir_write && !fetch_hold && !reset;
  assign PC_Write_Cond_o = dec_pc_write_cond && !reset;
  assign Mem_Read_o      = dec_mem_read && !reset;
  assign Mem_Write_o     = dec_mem_write && !reset;
  assign Reg_Write_o     = dec_reg_write && !reset;

  assign Illegal_o = illegal_q;
  assign State_o   = state_q;
  assign Retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: each issued instruction pushes
// its expected per-instruction profile; a monitor rebuilds the profile from the outputs.
module tb_multicycle_control;
  import rv_ctrl_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    Op_i;
  logic          Mem_Ready_i;
  logic          PC_Write_o;
  logic          PC_Write_Cond_o;
  logic [1:0]    PC_Src_o;
  logic          IorD_o;
  logic          Mem_Read_o;
  logic          Mem_Write_o;
  logic          IR_Write_o;
  logic [1:0]    Mem_to_Reg_o;
  logic          Reg_Write_o;
  logic [1:0]    ALU_Src_A_o;
  logic [1:0]    ALU_Src_B_o;
  logic [2:0]    ALU_Op_o;
  logic          Illegal_o;
  logic [3:0]    State_o;
  logic [RW-1:0] Retired_o;

  multicycle_control #(.USE_MEM_READY(1), .ENABLE_JUMPS(1), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .Op_i(Op_i), .Mem_Ready_i(Mem_Ready_i),
    .PC_Write_o(PC_Write_o), .PC_Write_Cond_o(PC_Write_Cond_o), .PC_Src_o(PC_Src_o),
    .IorD_o(IorD_o), .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o),
    .IR_Write_o(IR_Write_o), .Mem_to_Reg_o(Mem_to_Reg_o), .Reg_Write_o(Reg_Write_o),
    .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o),
    .Illegal_o(Illegal_o), .State_o(State_o), .Retired_o(Retired_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_I, K_U, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_ILL} kind_e;

  typedef struct {
    int cycles;
    int memReads;
    int memWrites;
    int regWrites;
    int irWrites;
    int pcWrites;
    int pcConds;
    int overlaps;
    int aluOpDec;
    int aluOpExec;
    int memToReg;
    int pcSrc;
    int retired;
    int illegal;
  } rec_t;

  rec_t expQ[$];
  rec_t acc;
  int   checks = 0;
  int   passes = 0;
  int   modelRetired = 0;
  int   sinceIr;
  bit   inProg = 0;
  bit   prevFetch = 0;
  bit   prevIll = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic [6:0] opcodeOf(input kind_e k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_U:     return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference profile of one instruction: fetch takes fw wait cycles, memory takes mw.
  function automatic rec_t modelInstr(input kind_e k, input int fw, input int mw, input int retBefore);
    rec_t e;
    int   retires;
    e.cycles = fw + 2; e.memReads = fw + 1; e.memWrites = 0; e.regWrites = 0;
    e.irWrites = 1; e.pcWrites = 1; e.pcConds = 0; e.overlaps = 0;
    e.aluOpDec = 2; e.aluOpExec = -1; e.memToReg = -1; e.pcSrc = -1; e.illegal = 0;
    retires = 1;
    case (k)
      K_R:     begin e.cycles += 2; e.regWrites = 1; e.memToReg = 0; e.aluOpExec = 0; end
      K_I:     begin e.cycles += 2; e.regWrites = 1; e.memToReg = 0; e.aluOpExec = 1; end
      K_U:     begin e.cycles += 2; e.regWrites = 1; e.memToReg = 0; e.aluOpExec = 4; end
      K_AUIPC: begin e.cycles += 2; e.regWrites = 1; e.memToReg = 0; e.aluOpExec = 2; end
      K_LOAD: begin
        e.cycles += 3 + mw; e.memReads += mw + 1; e.regWrites = 1; e.memToReg = 1; e.aluOpExec = 2;
      end
      K_STORE: begin e.cycles += 2 + mw; e.memWrites = mw + 1; e.aluOpExec = 2; end
      K_BR:    begin e.cycles += 1; e.pcConds = 1; e.pcSrc = 1; e.aluOpExec = 3; end
      K_JAL: begin
        e.cycles += 1; e.regWrites = 1; e.memToReg = 2; e.pcWrites = 2; e.pcSrc = 1; e.aluOpExec = 0;
      end
      K_JALR: begin
        e.cycles += 1; e.regWrites = 1; e.memToReg = 2; e.pcWrites = 2; e.pcSrc = 2; e.aluOpExec = 2;
      end
      default: begin e.illegal = 1; retires = 0; end
    endcase
    e.retired = (retBefore + retires) % (1 << RW);
    return e;
  endfunction

  function automatic logic readyFor(input kind_e k, input int i, input int fw, input int mw);
    if (i <= fw) return (i == fw);
    if ((k == K_LOAD || k == K_STORE) && i >= fw + 3) return (i == fw + 3 + mw);
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] opFor(input kind_e k, input int i, input int fw);
    if (i == fw + 1) return opcodeOf(k);
    if (i > fw + 1 && k == K_LOAD) return opcodeOf(K_STORE);
    if (i > fw + 1 && k == K_STORE) return opcodeOf(K_LOAD);
    return 7'($urandom);
  endfunction

  // Issue one whole instruction open-loop; returns at the start of the next cycle after it.
  task automatic applyStimulus(input kind_e k, input int fw, input int mw);
    rec_t e;
    e = modelInstr(k, fw, mw, modelRetired);
    modelRetired = e.retired;
    expQ.push_back(e);
    for (int i = 0; i < e.cycles; i++) begin
      Mem_Ready_i = readyFor(k, i, fw, mw);
      Op_i = opFor(k, i, fw);
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    Mem_Ready_i = 1'b1;
    @(negedge clk);
    checkOutput("strobesInReset",
                int'({PC_Write_o, PC_Write_Cond_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    modelRetired = 0;
    checkOutput("stateAfterReset", int'(State_o), int'(S_FETCH));
    checkOutput("retiredAfterReset", int'(Retired_o), 0);
    checkOutput("illegalAfterReset", int'(Illegal_o), 0);
  endtask

  task automatic present();
    rec_t e;
    checkOutput("expectedPending", int'(expQ.size() > 0), 1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("cycles", acc.cycles, e.cycles);
      checkOutput("memReads", acc.memReads, e.memReads);
      checkOutput("memWrites", acc.memWrites, e.memWrites);
      checkOutput("regWrites", acc.regWrites, e.regWrites);
      checkOutput("irWrites", acc.irWrites, e.irWrites);
      checkOutput("pcWrites", acc.pcWrites, e.pcWrites);
      checkOutput("pcConds", acc.pcConds, e.pcConds);
      checkOutput("rdWrOverlap", acc.overlaps, e.overlaps);
      checkOutput("aluOpDecode", acc.aluOpDec, e.aluOpDec);
      checkOutput("aluOpExec", acc.aluOpExec, e.aluOpExec);
      checkOutput("memToReg", acc.memToReg, e.memToReg);
      checkOutput("pcSrc", acc.pcSrc, e.pcSrc);
      checkOutput("retired", int'(Retired_o), e.retired);
      checkOutput("illegal", int'(Illegal_o), e.illegal);
    end
  endtask

  // Monitor: an instruction ends when the next fetch begins, or when Illegal_o rises.
  initial begin
    bit isFetch;
    forever begin
      @(negedge clk);
      isFetch = Mem_Read_o && !IorD_o;
      if (reset) begin
        inProg = 0; prevFetch = 0; prevIll = 0;
      end else begin
        if (isFetch && !prevFetch && inProg) present();
        if (Illegal_o && !prevIll && inProg) begin
          present();
          inProg = 0;
        end
        if (isFetch && !prevFetch) begin
          acc = '{default: 0};
          acc.aluOpDec = -1; acc.aluOpExec = -1; acc.memToReg = -1; acc.pcSrc = -1;
          sinceIr = -1;
          inProg = 1;
        end
        if (inProg) begin
          acc.cycles++;
          acc.memReads  += int'(Mem_Read_o);
          acc.memWrites += int'(Mem_Write_o);
          acc.regWrites += int'(Reg_Write_o);
          acc.irWrites  += int'(IR_Write_o);
          acc.pcWrites  += int'(PC_Write_o);
          acc.pcConds   += int'(PC_Write_Cond_o);
          acc.overlaps  += int'(Mem_Read_o && Mem_Write_o);
          if (Reg_Write_o) acc.memToReg = int'(Mem_to_Reg_o);
          if (PC_Write_Cond_o || (PC_Write_o && !IR_Write_o)) acc.pcSrc = int'(PC_Src_o);
          if (IR_Write_o) sinceIr = 0;
          else if (sinceIr >= 0) sinceIr++;
          if (sinceIr == 1) acc.aluOpDec = int'(ALU_Op_o);
          if (sinceIr == 2) acc.aluOpExec = int'(ALU_Op_o);
        end
        prevFetch = isFetch;
        prevIll = Illegal_o;
      end
    end
  end

  initial begin
    kind_e k;
    reset = 1'b1;
    Op_i = 7'd0;
    Mem_Ready_i = 1'b0;
    doReset();

    applyStimulus(K_I, 0, 0);
    applyStimulus(K_LOAD, 0, 3);
    applyStimulus(K_STORE, 1, 2);
    applyStimulus(K_BR, 0, 0);
    applyStimulus(K_JAL, 2, 0);
    applyStimulus(K_JALR, 0, 0);
    applyStimulus(K_U, 1, 0);
    applyStimulus(K_AUIPC, 0, 0);
    applyStimulus(K_R, 0, 0);

    for (int n = 0; n < 30; n++) begin
      k = kind_e'($urandom_range(0, 8));
      applyStimulus(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    for (int n = 0; n < 16; n++) applyStimulus(K_I, 0, 0);

    // Abandon a load while it waits on memory.
    for (int i = 0; i < 5; i++) begin
      Mem_Ready_i = (i == 0);
      Op_i = (i == 1) ? opcodeOf(K_LOAD) : 7'($urandom);
      @(posedge clk); #1;
    end
    Mem_Ready_i = 1'b0;
    @(negedge clk);
    checkOutput("midLoadState", int'(State_o), int'(S_MEM_RD));
    @(posedge clk); #1;
    doReset();

    applyStimulus(K_I, 0, 0);
    applyStimulus(K_ILL, 1, 0);
    for (int i = 0; i < 3; i++) begin
      Mem_Ready_i = 1'($urandom);
      Op_i = opcodeOf(K_I);
      @(negedge clk);
      checkOutput("trapState", int'(State_o), int'(S_TRAP));
      checkOutput("trapSticky", int'(Illegal_o), 1);
      checkOutput("trapStrobes",
                  int'({PC_Write_o, PC_Write_Cond_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o}), 0);
      @(posedge clk); #1;
    end
    doReset();

    applyStimulus(K_STORE, 0, 1);
    applyStimulus(K_I, 0, 0);
    Mem_Ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
